// File: rtl/lockstep_divergence_monitor_if.sv
// Report bus between a lockstep pair's comparator and its reader.
// Carries the sampled copy outputs, control pulses and the report record.
interface lockstep_divergence_monitor_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic             valid;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ack;
    logic             armed;
    logic             diverged;
    logic             report_valid;
    logic [CNT_W-1:0] first_cycle;
    logic [WIDTH-1:0] first_a;
    logic [WIDTH-1:0] first_b;
    logic [CNT_W-1:0] mismatch_count;

    modport master (
        output start, valid, a_in, b_in, ack,
        input  armed, diverged, report_valid,
        input  first_cycle, first_a, first_b,
        input  mismatch_count
    );

    modport slave (
        input  start, valid, a_in, b_in, ack,
        output armed, diverged, report_valid,
        output first_cycle, first_a, first_b,
        output mismatch_count
    );
endinterface

// File: rtl/lockstep_divergence_monitor.sv
// Compares the outputs of two lockstep copies, latches the first
// divergence into a one-shot report and counts every later mismatch.
module lockstep_divergence_monitor #(
    parameter int WIDTH  = 32,
    parameter int WARMUP = 2,
    parameter int CNT_W  = 16
) (
    input logic clk,
    input logic reset,
    lockstep_divergence_monitor_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_COMPARE,
        S_REPORT,
        S_DONE
    } state_t;

    localparam int WW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [WW-1:0] W_LAST = WW'(WARMUP - 1);

    state_t state, next;

    logic [CNT_W-1:0] cyc_cnt;
    logic [WW-1:0]    warm_cnt;
    logic [CNT_W-1:0] mis_cnt;
    logic             div_q;
    logic             rv_q;
    logic [CNT_W-1:0] fc_q;
    logic [WIDTH-1:0] fa_q;
    logic [WIDTH-1:0] fb_q;
    logic             mism;
    logic             armed;

    assign mism  = bus.valid && (bus.a_in != bus.b_in);
    assign armed = (state == S_WARMUP) || (state == S_COMPARE) ||
                   (state == S_REPORT);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next;
    end

    // Next-state logic; start overrides everything, including ack.
    always_comb begin
        next = state;
        unique case (state)
            S_IDLE:    next = S_IDLE;
            S_WARMUP:  if (warm_cnt == W_LAST) next = S_COMPARE;
            S_COMPARE: if (mism) next = S_REPORT;
            S_REPORT:  if (bus.ack) next = S_DONE;
            S_DONE:    next = S_DONE;
            default:   next = S_IDLE;
        endcase
        if (bus.start) next = (WARMUP == 0) ? S_COMPARE : S_WARMUP;
    end

    // Counters and the first-divergence record.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_cnt  <= '0;
            warm_cnt <= '0;
            mis_cnt  <= '0;
            div_q    <= 1'b0;
            rv_q     <= 1'b0;
            fc_q     <= '0;
            fa_q     <= '0;
            fb_q     <= '0;
        end else if (bus.start) begin
            cyc_cnt  <= '0;
            warm_cnt <= '0;
            mis_cnt  <= '0;
            div_q    <= 1'b0;
            rv_q     <= 1'b0;
            fc_q     <= '0;
            fa_q     <= '0;
            fb_q     <= '0;
        end else begin
            if (armed && cyc_cnt != MAX) cyc_cnt <= cyc_cnt + 1'b1;
            if (state == S_WARMUP) warm_cnt <= warm_cnt + 1'b1;
            if (state == S_COMPARE && mism) begin
                fc_q    <= cyc_cnt;
                fa_q    <= bus.a_in;
                fb_q    <= bus.b_in;
                div_q   <= 1'b1;
                rv_q    <= 1'b1;
                mis_cnt <= CNT_W'(1);
            end
            if ((state == S_REPORT || state == S_DONE) && mism &&
                mis_cnt != MAX)
                mis_cnt <= mis_cnt + 1'b1;
            if (state == S_REPORT && bus.ack) rv_q <= 1'b0;
        end
    end

    assign bus.armed          = armed;
    assign bus.diverged       = div_q;
    assign bus.report_valid   = rv_q;
    assign bus.first_cycle    = fc_q;
    assign bus.first_a        = fa_q;
    assign bus.first_b        = fb_q;
    assign bus.mismatch_count = mis_cnt;

    // Invariants of the report record.
    a_rv_div: assert property (@(posedge clk) disable iff (reset)
        rv_q |-> div_q);
    a_cnt0: assert property (@(posedge clk) disable iff (reset)
        !div_q |-> (mis_cnt == '0));
    a_idle: assert property (@(posedge clk) disable iff (reset)
        (state == S_IDLE) |-> !armed);
endmodule

// File: tb/tb_lockstep_divergence_monitor.sv
// Directed bench for the lockstep divergence monitor.
// Covers warmup masking, reporting, saturation, start/ack and reset.
module tb_lockstep_divergence_monitor;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lockstep_divergence_monitor_if #(.WIDTH(32), .CNT_W(16)) b0();
    lockstep_divergence_monitor_if #(.WIDTH(8), .CNT_W(4)) b1();

    lockstep_divergence_monitor #(
        .WIDTH(32), .WARMUP(2), .CNT_W(16)
    ) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));

    lockstep_divergence_monitor #(
        .WIDTH(8), .WARMUP(2), .CNT_W(4)
    ) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic step0(input logic v, input logic [31:0] a,
                         input logic [31:0] b);
        b0.valid = v;
        b0.a_in  = a;
        b0.b_in  = b;
        cyc();
    endtask

    task automatic step1(input logic v, input logic [7:0] a,
                         input logic [7:0] b);
        b1.valid = v;
        b1.a_in  = a;
        b1.b_in  = b;
        cyc();
    endtask

    task automatic start0();
        b0.start = 1'b1;
        cyc();
        b0.start = 1'b0;
    endtask

    task automatic start1();
        b1.start = 1'b1;
        cyc();
        b1.start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

    initial begin
        b0.start = 0; b0.valid = 0; b0.ack = 0;
        b0.a_in = 0;  b0.b_in = 0;
        b1.start = 0; b1.valid = 0; b1.ack = 0;
        b1.a_in = 0;  b1.b_in = 0;
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_armed", 64'(b0.armed), 64'd0);
        chk("rst_div", 64'(b0.diverged), 64'd0);
        chk("rst_rv", 64'(b0.report_valid), 64'd0);
        chk("rst_cnt", 64'(b0.mismatch_count), 64'd0);
        chk("rst_fa", 64'(b0.first_a), 64'd0);

        // equal data for 20 cycles
        start0();
        for (int k = 0; k < 20; k++) step0(1'b1, 32'd5, 32'd5);
        chk("eq_armed", 64'(b0.armed), 64'd1);
        chk("eq_div", 64'(b0.diverged), 64'd0);
        chk("eq_cnt", 64'(b0.mismatch_count), 64'd0);
        chk("eq_rv", 64'(b0.report_valid), 64'd0);

        // warmup mismatch ignored, first report at cycle 6
        start0();
        for (int k = 0; k <= 6; k++) begin
            if (k == 1)      step0(1'b1, 32'd3, 32'd4);
            else if (k == 6) step0(1'b1, 32'h10, 32'h11);
            else             step0(1'b1, 32'd5, 32'd5);
            if (k == 5) chk("pre_div", 64'(b0.diverged), 64'd0);
        end
        chk("r_rv", 64'(b0.report_valid), 64'd1);
        chk("r_div", 64'(b0.diverged), 64'd1);
        chk("r_fc", 64'(b0.first_cycle), 64'd6);
        chk("r_fa", 64'(b0.first_a), 64'h10);
        chk("r_fb", 64'(b0.first_b), 64'h11);
        chk("r_cnt", 64'(b0.mismatch_count), 64'd1);

        // further mismatches, invalid cycle, then ack
        step0(1'b1, 32'd5, 32'd5);
        step0(1'b1, 32'd1, 32'd2);
        step0(1'b1, 32'd7, 32'd8);
        step0(1'b0, 32'd1, 32'd2);
        chk("c10_cnt", 64'(b0.mismatch_count), 64'd3);
        chk("c10_rv", 64'(b0.report_valid), 64'd1);
        b0.ack = 1'b1;
        step0(1'b1, 32'd5, 32'd5);
        b0.ack = 1'b0;
        chk("ack_rv", 64'(b0.report_valid), 64'd0);
        chk("ack_cnt", 64'(b0.mismatch_count), 64'd3);
        chk("ack_fc", 64'(b0.first_cycle), 64'd6);
        chk("ack_fa", 64'(b0.first_a), 64'h10);
        chk("ack_fb", 64'(b0.first_b), 64'h11);
        chk("ack_div", 64'(b0.diverged), 64'd1);
        chk("done_armed", 64'(b0.armed), 64'd0);
        step0(1'b1, 32'hffff_ffff, 32'h7fff_ffff);
        chk("done_cnt", 64'(b0.mismatch_count), 64'd4);
        chk("done_rv", 64'(b0.report_valid), 64'd0);

        // transition-edge mismatch ignored, then start+ack in REPORT
        start0();
        step0(1'b1, 32'd5, 32'd5);
        step0(1'b1, 32'd1, 32'd0);
        chk("edge_div", 64'(b0.diverged), 64'd0);
        step0(1'b1, 32'd7, 32'd9);
        chk("c2_rv", 64'(b0.report_valid), 64'd1);
        chk("c2_fc", 64'(b0.first_cycle), 64'd2);
        b0.start = 1'b1;
        b0.ack = 1'b1;
        step0(1'b1, 32'd5, 32'd5);
        b0.start = 1'b0;
        b0.ack = 1'b0;
        chk("sa_rv", 64'(b0.report_valid), 64'd0);
        chk("sa_div", 64'(b0.diverged), 64'd0);
        chk("sa_cnt", 64'(b0.mismatch_count), 64'd0);
        chk("sa_fa", 64'(b0.first_a), 64'd0);
        chk("sa_armed", 64'(b0.armed), 64'd1);
        step0(1'b1, 32'd1, 32'd2);
        step0(1'b1, 32'd1, 32'd2);
        chk("sa_warm", 64'(b0.diverged), 64'd0);

        // async reset while in REPORT
        step0(1'b1, 32'd1, 32'd2);
        chk("pr_rv", 64'(b0.report_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_rv", 64'(b0.report_valid), 64'd0);
        chk("ar_div", 64'(b0.diverged), 64'd0);
        chk("ar_cnt", 64'(b0.mismatch_count), 64'd0);
        chk("ar_armed", 64'(b0.armed), 64'd0);
        chk("ar_fb", 64'(b0.first_b), 64'd0);
        cyc();
        reset = 1'b0;
        b0.ack = 1'b1;
        step0(1'b1, 32'd1, 32'd2);
        b0.ack = 1'b0;
        chk("ar_ack_rv", 64'(b0.report_valid), 64'd0);
        chk("ar_ack_arm", 64'(b0.armed), 64'd0);
        chk("ar_ack_cnt", 64'(b0.mismatch_count), 64'd0);

        // CNT_W=4: first_cycle from saturated cycle counter
        start1();
        for (int k = 0; k < 20; k++) step1(1'b1, 8'd9, 8'd9);
        step1(1'b1, 8'd1, 8'd2);
        chk("s_fc", 64'(b1.first_cycle), 64'd15);
        chk("s_cnt1", 64'(b1.mismatch_count), 64'd1);

        // CNT_W=4: mismatch every cycle for 30 cycles
        start1();
        for (int k = 0; k < 30; k++) begin
            step1(1'b1, 8'h55, 8'haa);
            if (k == 16) chk("s_c16", 64'(b1.mismatch_count), 64'd15);
        end
        chk("s_sat", 64'(b1.mismatch_count), 64'd15);
        chk("s_fc2", 64'(b1.first_cycle), 64'd2);
        chk("s_div", 64'(b1.diverged), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
